// File: rtl/gcode_pkg.sv
// Shared types and constants for the Gray-coded position tracker.
//   gcode_t  : 4-bit Gray sample / 4-bit binary value
//   state_e  : tracker FSM states
//   DELTA_UP : modulo-16 difference of a single up step
//   DELTA_DN : modulo-16 difference of a single down step
package gcode_pkg;

   localparam int unsigned GCODE_W = 4;

   typedef logic [GCODE_W-1:0] gcode_t;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      TRACK = 2'd1,
      EMIT  = 2'd2
   } state_e;

   localparam gcode_t DELTA_UP = 4'd1;
   localparam gcode_t DELTA_DN = 4'd15;

endpackage

// File: rtl/gcode_decode.sv
// Purely combinational 4-bit reflected Gray to binary decoder.
// Ports:
//   gray : Gray-coded input
//   bin  : binary equivalent (bin[3]=gray[3], bin[i]=bin[i+1]^gray[i])
module gcode_decode (
   input  logic [3:0] gray,
   output logic [3:0] bin
);

   // Each binary bit is the XOR of all Gray bits at or above it.
   assign bin = {gray[3],
                 gray[3] ^ gray[2],
                 gray[3] ^ gray[2] ^ gray[1],
                 gray[3] ^ gray[2] ^ gray[1] ^ gray[0]};

endmodule

// File: rtl/gcode_pos_tracker.sv
// Tracks a wide binary position from a stream of 4-bit Gray samples and
// emits one update message per single-step move; other jumps are flagged.
// Optional macro GCODE_POS_TRACKER_DEBOUNCE_EN: a changed sample is only
// acted on once the next accepted sample repeats it.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   in_val/in_rdy    : sample handshake (in_rdy is combinational)
//   in_              : Gray-coded sample
//   out_val/out_rdy  : update message handshake
//   out_pos          : accumulated binary position
//   out_dir          : 1 = up step, 0 = down step or error
//   out_err          : message reports an illegal jump
module gcode_pos_tracker
   import gcode_pkg::*;
#(
   parameter int unsigned p_pos_nbits = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_val,
   output logic                   in_rdy,
   input  logic [3:0]             in_,
   output logic                   out_val,
   input  logic                   out_rdy,
   output logic [p_pos_nbits-1:0] out_pos,
   output logic                   out_dir,
   output logic                   out_err
);

   localparam int unsigned PW = p_pos_nbits;

   state_e          state_q, state_d;
   gcode_t          base_q, base_d;
   logic [PW-1:0]   pos_q, pos_d;
   logic [PW-1:0]   opos_q, opos_d;
   logic            odir_q, odir_d;
   logic            oerr_q, oerr_d;
   gcode_t          bin;
   gcode_t          delta;
   logic            accept;
   logic            act_c;
`ifdef GCODE_POS_TRACKER_DEBOUNCE_EN
   gcode_t          cand_q, cand_d;
   logic            cand_vld_q, cand_vld_d;
`endif

   gcode_decode u_decode (
      .gray (in_),
      .bin  (bin)
   );

   // Handshake and message-pending view of the FSM.
   assign out_val = (state_q == EMIT);
   assign in_rdy  = !out_val || out_rdy;
   assign accept  = in_val && in_rdy;
   assign delta   = bin - base_q;

   assign out_pos = opos_q;
   assign out_dir = odir_q;
   assign out_err = oerr_q;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= INIT;
      else       state_q <= state_d;
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         base_q <= '0;
         pos_q  <= '0;
         opos_q <= '0;
         odir_q <= 1'b0;
         oerr_q <= 1'b0;
      end else begin
         base_q <= base_d;
         pos_q  <= pos_d;
         opos_q <= opos_d;
         odir_q <= odir_d;
         oerr_q <= oerr_d;
      end
   end

`ifdef GCODE_POS_TRACKER_DEBOUNCE_EN
   // Candidate holding the first occurrence of a changed sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         cand_q     <= '0;
         cand_vld_q <= 1'b0;
      end else begin
         cand_q     <= cand_d;
         cand_vld_q <= cand_vld_d;
      end
   end
`endif

   // Next-state, baseline, position and message logic.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      pos_d   = pos_q;
      opos_d  = opos_q;
      odir_d  = odir_q;
      oerr_d  = oerr_q;
      act_c   = 1'b0;
`ifdef GCODE_POS_TRACKER_DEBOUNCE_EN
      cand_d     = cand_q;
      cand_vld_d = cand_vld_q;
`endif

      case (state_q)
         INIT: begin
            if (accept) begin
               base_d  = bin;
               pos_d   = PW'(bin);
               state_d = TRACK;
`ifdef GCODE_POS_TRACKER_DEBOUNCE_EN
               cand_vld_d = 1'b0;
`endif
            end
         end

         TRACK, EMIT: begin
            // Consumed message with nothing new to replace it.
            if (state_q == EMIT && out_rdy) state_d = TRACK;

            if (accept && delta != '0) begin
`ifdef GCODE_POS_TRACKER_DEBOUNCE_EN
               if (cand_vld_q && cand_q == bin) begin
                  act_c      = 1'b1;
                  cand_vld_d = 1'b0;
               end else begin
                  cand_d     = bin;
                  cand_vld_d = 1'b1;
               end
`else
               act_c = 1'b1;
`endif
            end
`ifdef GCODE_POS_TRACKER_DEBOUNCE_EN
            else if (accept) begin
               cand_vld_d = 1'b0;
            end
`endif

            if (act_c) begin
               base_d  = bin;
               state_d = EMIT;
               if (delta == DELTA_UP) begin
                  pos_d  = pos_q + PW'(1);
                  opos_d = pos_q + PW'(1);
                  odir_d = 1'b1;
                  oerr_d = 1'b0;
               end else if (delta == DELTA_DN) begin
                  pos_d  = pos_q - PW'(1);
                  opos_d = pos_q - PW'(1);
                  odir_d = 1'b0;
                  oerr_d = 1'b0;
               end else begin
                  opos_d = pos_q;
                  odir_d = 1'b0;
                  oerr_d = 1'b1;
               end
            end
         end

         default: state_d = INIT;
      endcase
   end

endmodule

// File: tb/tb_gcode_pos_tracker.sv
// Scoreboard bench for gcode_pos_tracker: directed cases plus randomized
// samples checked against a behavioural position model.
module tb_gcode_pos_tracker;

   localparam int P   = 8;
   localparam int MOD = 1 << P;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_val;
   logic         in_rdy;
   logic [3:0]   in_;
   logic         out_val;
   logic         out_rdy;
   logic [P-1:0] out_pos;
   logic         out_dir;
   logic         out_err;

   always #5 clk = ~clk;

   gcode_pos_tracker #(.p_pos_nbits(P)) dut (
      .clk     (clk),
      .reset   (reset),
      .in_val  (in_val),
      .in_rdy  (in_rdy),
      .in_     (in_),
      .out_val (out_val),
      .out_rdy (out_rdy),
      .out_pos (out_pos),
      .out_dir (out_dir),
      .out_err (out_err)
   );

   typedef struct {
      int pos;
      int dir;
      int err;
   } msg_t;

   msg_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model state.
   bit have_base;
   int base;
   int pos;
   bit cvld;
   int cand;

   function automatic int g2b(int g);
      return (g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3)) & 15;
   endfunction

   function automatic int b2g(int b);
      return (b ^ (b >> 1)) & 15;
   endfunction

   task automatic push_msg(int p, int d, int e);
      msg_t m;
      m.pos = p; m.dir = d; m.err = e;
      sb.push_back(m);
   endtask

   task automatic model_accept(int g);
      int b;
      int d;
      b = g2b(g);
      if (!have_base) begin
         have_base = 1'b1;
         base      = b;
         pos       = b;
         cvld      = 1'b0;
         return;
      end
      d = (b - base + 16) % 16;
`ifdef GCODE_POS_TRACKER_DEBOUNCE_EN
      if (d == 0) begin
         cvld = 1'b0;
         return;
      end
      if (!(cvld && cand == b)) begin
         cand = b;
         cvld = 1'b1;
         return;
      end
      cvld = 1'b0;
`endif
      base = b;
      if (d == 1) begin
         pos = (pos + 1) % MOD;
         push_msg(pos, 1, 0);
      end else if (d == 15) begin
         pos = (pos + MOD - 1) % MOD;
         push_msg(pos, 0, 0);
      end else if (d != 0) begin
         push_msg(pos, 0, 1);
      end
   endtask

   // Monitor: compares the presented message with the scoreboard head and
   // retires it when the consumer takes it.
   always @(negedge clk) begin
      #2;
      if (reset === 1'b0) begin
         checks++;
         if (out_val !== (sb.size() != 0)) begin
            failures++;
            $display("FAIL out_val act=%0b exp=%0b t=%0t", out_val, sb.size() != 0, $time);
         end else if (out_val) begin
            checks++;
            if (out_pos !== P'(sb[0].pos) || out_dir !== 1'(sb[0].dir) ||
                out_err !== 1'(sb[0].err)) begin
               failures++;
               $display("FAIL msg act pos=%0d dir=%0b err=%0b exp pos=%0d dir=%0d err=%0d t=%0t",
                        out_pos, out_dir, out_err, sb[0].pos, sb[0].dir, sb[0].err, $time);
            end
         end
      end
      if (out_rdy && sb.size() > 0) void'(sb.pop_front());
   end

   // One stimulus cycle; the monitor has already retired a consumed message,
   // so an empty scoreboard means the tracker must be ready.
   task automatic cycle(bit v, int g, bit r);
      bit exp_rdy;
      @(negedge clk);
      in_val  = v;
      in_     = 4'(g);
      out_rdy = r;
      #3;
      exp_rdy = (sb.size() == 0);
      checks++;
      if (in_rdy !== exp_rdy) begin
         failures++;
         $display("FAIL in_rdy act=%0b exp=%0b t=%0t", in_rdy, exp_rdy, $time);
      end
      if (v && exp_rdy) model_accept(g);
   endtask

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset   = 1'b1;
      in_val  = 1'b0;
      out_rdy = 1'b0;
      #3;
      sb.delete();
      have_base = 1'b0;
      base      = 0;
      pos       = 0;
      cvld      = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #3;
      chk("rst_out_val", int'(out_val), 0);
      chk("rst_out_pos", int'(out_pos), 0);
      chk("rst_out_dir", int'(out_dir), 0);
      chk("rst_out_err", int'(out_err), 0);
      chk("rst_in_rdy",  int'(in_rdy),  1);
   endtask

   // Holds the consumer off for a cycle and checks the pending message.
   task automatic hold_check(int p, int d, int e);
      cycle(1'b0, 0, 1'b0);
      chk("hold_val", int'(out_val), 1);
      chk("hold_pos", int'(out_pos), p);
      chk("hold_dir", int'(out_dir), d);
      chk("hold_err", int'(out_err), e);
   endtask

   initial begin
      reset   = 1'b1;
      in_val  = 1'b0;
      in_     = 4'd0;
      out_rdy = 1'b0;
      do_reset();

`ifdef GCODE_POS_TRACKER_DEBOUNCE_EN
      cycle(1'b1, 4'b0000, 1'b1);
      cycle(1'b1, 4'b0001, 1'b1);
      cycle(1'b1, 4'b0000, 1'b1);
      cycle(1'b1, 4'b0001, 1'b1);
      cycle(1'b1, 4'b0001, 1'b1);
      hold_check(1, 1, 0);
      cycle(1'b0, 0, 1'b1);
`else
      // Simple up steps.
      cycle(1'b1, 4'b0000, 1'b1);
      cycle(1'b1, 4'b0001, 1'b1);
      hold_check(1, 1, 0);
      cycle(1'b1, 4'b0011, 1'b1);
      hold_check(2, 1, 0);

      // Position wrap in both directions.
      do_reset();
      cycle(1'b1, 4'b0000, 1'b1);
      cycle(1'b1, 4'b1000, 1'b1);
      hold_check(255, 0, 0);
      cycle(1'b1, 4'b0000, 1'b1);
      hold_check(0, 1, 0);

      // Illegal jump then resync.
      do_reset();
      cycle(1'b1, 4'b0001, 1'b1);
      cycle(1'b1, 4'b0110, 1'b1);
      hold_check(1, 0, 1);
      cycle(1'b1, 4'b0111, 1'b1);
      hold_check(2, 1, 0);

      // Backpressure then replacement.
      repeat (5) cycle(1'b1, 4'b0101, 1'b0);
      cycle(1'b1, 4'b0101, 1'b1);
      hold_check(3, 1, 0);

      // Repeated identical samples.
      repeat (4) cycle(1'b1, 4'b0011, 1'b1);
      cycle(1'b0, 0, 1'b1);

      // Reset while a message is pending.
      cycle(1'b1, 4'b0010, 1'b0);
      do_reset();
      cycle(1'b1, 4'b0010, 1'b1);
      cycle(1'b0, 0, 1'b1);
      cycle(1'b1, 4'b0011, 1'b1);
      hold_check(2, 0, 0);
`endif

      // Randomized walk with occasional jumps, stalls and resets.
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         int k;
         int nb;
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            k = int'($urandom_range(0, 9));
            if (k < 3)      nb = base;
            else if (k < 6) nb = (base + 1) % 16;
            else if (k < 8) nb = (base + 15) % 16;
            else            nb = int'($urandom_range(0, 15));
            cycle($urandom_range(0, 9) < 7, b2g(nb), $urandom_range(0, 9) < 7);
         end
      end

      repeat (3) cycle(1'b0, 0, 1'b1);
      chk("drain_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
